mux4_rr_arbiter: RTL

//  Round-robin arbiter that shares one 4:1 8-bit mux datapath among four requesters.
//  It owns the mux select, grants one requester at a time and holds the grant for a burst.
//  It presents the selected byte on a valid/ready output port.

---
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 byte mux, with a valid/ready output port.
// Optional burst limit enabled by defining ARB_BURST_LIMIT_EN.

module mux4t1_8b (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] C,
  input  logic [7:0] D,
  input  logic [1:0] sel,
  output logic [7:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = A;
      2'd1:    y = B;
      2'd2:    y = C;
      default: y = D;
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] C,
  input  logic [7:0] D,
  input  logic       out_ready,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] offset;
  logic [1:0] winner;
  logic       accept;
  logic       limit_hit;
  logic       release_grant;

  // Rotate so bit 0 is the current highest-priority source, then take the first set bit.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: 4];

  always_comb begin
    if (req_rot[0])      offset = 2'd0;
    else if (req_rot[1]) offset = 2'd1;
    else if (req_rot[2]) offset = 2'd2;
    else                 offset = 2'd3;
  end

  assign winner    = ptr + offset;
  assign out_valid = busy & req[sel];
  assign accept    = out_valid & out_ready;

`ifdef ARB_BURST_LIMIT_EN
  assign limit_hit = accept && (beat_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign release_grant = !req[sel] || limit_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (|req) begin
            state    <= StGrant;
            grant    <= 4'b0001 << winner;
            sel      <= winner;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        StGrant: begin
          if (accept && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          // Releasing source drops to lowest priority; sel is left as-is while idle.
          if (release_grant) begin
            state    <= StIdle;
            grant    <= 4'b0000;
            ptr      <= sel + 2'd1;
            beat_cnt <= '0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          grant <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mux4t1_8b u_mux (
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .sel(sel),
    .y  (out_data)
  );

endmodule
